cc_alu_arbiter: RTL and testbench
=================================

// Module: cc_alu_arbiter
// PURPOSE
//  Shares one CC_ALU instance between two requesters (R0, R1) using round-robin arbitration.
//  Latches the winner's operands and ALU selection, then drives the ALU for one cycle.
//  Registers the result and the active-high NZVC flags, and returns them over a valid/ready handshake.
//  Sits between the datapath control units and the ALU in uDataPath.
// PARAMETERS
//  DATAWIDTH_BUS            32  operand/result width
//  DATAWIDTH_ALU_SELECTION   4  ALU selection code width
//  MAX_HOLD                 15  max cycles RESP waits for ready before drop (>=1)
// PORTS
//  CC_ALUARB_CLOCK_50        in   1   clock, rising edge
//  CC_ALUARB_RESET_InLow     in   1   asynchronous active-low reset
//  CC_ALUARB_Req_In[1:0]     in   2   per-requester request, held until grant
//  CC_ALUARB_Sel0_In/Sel1_In in   SEL ALU selection per requester
//  CC_ALUARB_A0_In/A1_In     in   BUS operand A per requester
//  CC_ALUARB_B0_In/B1_In     in   BUS operand B per requester
//  CC_ALUARB_Gnt_Out[1:0]    out  2   one-cycle grant pulse (operands latched)
//  CC_ALUARB_Valid_Out[1:0]  out  2   response valid, owner bit only
//  CC_ALUARB_Rdy_In[1:0]     in   2   response accepted by requester
//  CC_ALUARB_Data_Out        out  BUS registered ALU result
//  CC_ALUARB_Flags_Out       out  4   registered {N,Z,V,C}, active-high
//  CC_ALUARB_Drop_Out        out  1   one-cycle pulse on response timeout
//  CC_ALUARB_PSR_Out         out  4   sticky condition codes {N,Z,V,C}
//  CC_ALUARB_AluA_Out/AluB_Out out BUS to ALU DataBUSA/B_In
//  CC_ALUARB_AluSel_Out      out  SEL to ALU Selection_In
//  CC_ALUARB_AluData_In      in   BUS from ALU DataBUS_Out
//  CC_ALUARB_AluFlags_InLow  in   4   from ALU {Negative,Zero,Overflow,Carry}_OutLow
// BEHAVIOUR
//  Reset (async, RESET_InLow=0): FSM=IDLE; all outputs 0; last-winner ptr=1 (R0 has priority next).
//  FSM IDLE: if Req!=0, pick winner: single request wins; both -> the requester != last-winner.
//    Latch Sel/A/B of winner into op regs; pulse Gnt[w] for that cycle; go EXEC.
//  EXEC (1 cycle): AluA/AluB/AluSel driven from op regs (also held in other states).
//    At clock edge, capture Data_Out=AluData_In and Flags_Out=~AluFlags_InLow; go RESP.
//  RESP: Valid_Out[w]=1. Data/Flags are stable while valid.
//    If Rdy_In[w]=1: clear Valid; last-winner<=w; go IDLE.
//    Rdy_In of the non-owner is ignored.
//  Timeout: hold counter counts RESP cycles. If it reaches MAX_HOLD without ready:
//    Drop_Out pulses 1 cycle; Valid cleared; last-winner<=w; go IDLE.
//  Latency: request seen in IDLE at cycle n -> Gnt at n -> Valid at n+2.
//    Min issue interval is 3 cycles.
//  Requests arriving in EXEC/RESP wait; no grant outside IDLE. Req dropped before grant: no effect.
//  Width: counter is $clog2(MAX_HOLD+1) bits and saturates.
//    Selections outside 0..15 cannot occur (4-bit).
// CONFIGURATION
//  CC_ALUARB_PSR_EN defined: PSR_Out is updated with Flags at the EXEC->RESP edge, CC selections only.
//    CC selections are 4'b0000..4'b0011 (ANDCC/ORCC/NORCC/ADDCC).
//    PSR holds its value otherwise; it resets to 0.
//  CC_ALUARB_PSR_EN undefined: PSR_Out tied 4'b0000 and no PSR register is inferred.
// STRUCTURE
//  Shared package cc_alu_pkg:
//    FSM state typedef {IDLE,EXEC,RESP}
//    ALU selection localparams (SEL_ANDCC=0 .. SEL_ADDCC=3, SEL_ADD=8, SEL_INCPC=14)
//    CC_SEL_MAX=3
//  One sub-module cc_alu_rr_arb2: 2-way round-robin pick, inputs req[1:0] and last, output winner/valid.
//  ALU is instantiated outside this block.
// TESTING
//  Req=01, A0=5, B0=7, Sel0=ADD(8), Rdy0=1 -> Gnt=01 at n, Valid=01 at n+2, Data=12, Flags=0000.
//  Req=11 held, both Rdy=1 -> grants alternate 01,10,01,10; after reset the first grant is R0.
//  R1 ADDCC A=32'h7FFFFFFF, B=1 -> Data=32'h80000000, Flags N=1,V=1.
//    With PSR_EN, PSR=1010; a following ADD(8) leaves PSR unchanged.
//  R0 ADDCC A=32'hFFFFFFFF, B=1 -> Data=0, Flags Z=1,C=1 (0101).
//  Valid with Rdy low for MAX_HOLD cycles -> Drop pulse, Valid=0, pending R1 granted next.
//  Reset asserted during RESP -> Valid, Gnt, Data, Flags, PSR all 0 asynchronously; FSM back to IDLE.

Source files
------------

// File: rtl/cc_alu_pkg.sv
// Shared definitions for the CC_ALU arbiter slice: FSM state encoding and
// ALU selection codes. The condition-code selections are 0..CC_SEL_MAX.
package cc_alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] SEL_ANDCC = 4'd0;
   localparam logic [3:0] SEL_ORCC  = 4'd1;
   localparam logic [3:0] SEL_NORCC = 4'd2;
   localparam logic [3:0] SEL_ADDCC = 4'd3;
   localparam logic [3:0] SEL_ADD   = 4'd8;
   localparam logic [3:0] SEL_INCPC = 4'd14;

   localparam int CC_SEL_MAX = 3;

endpackage

// File: rtl/cc_alu_arbiter_if.sv
// Requester and ALU side signals of the CC_ALU arbiter.
// master: requesters plus the external ALU; slave: the arbiter itself.
interface cc_alu_arbiter_if #(
   parameter int DATAWIDTH_BUS           = 32,
   parameter int DATAWIDTH_ALU_SELECTION = 4
);
   logic [1:0]                         CC_ALUARB_Req_In;
   logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_Sel0_In;
   logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_Sel1_In;
   logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_A0_In;
   logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_A1_In;
   logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_B0_In;
   logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_B1_In;
   logic [1:0]                         CC_ALUARB_Gnt_Out;
   logic [1:0]                         CC_ALUARB_Valid_Out;
   logic [1:0]                         CC_ALUARB_Rdy_In;
   logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_Data_Out;
   logic [3:0]                         CC_ALUARB_Flags_Out;
   logic                               CC_ALUARB_Drop_Out;
   logic [3:0]                         CC_ALUARB_PSR_Out;
   logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_AluA_Out;
   logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_AluB_Out;
   logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_AluSel_Out;
   logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_AluData_In;
   logic [3:0]                         CC_ALUARB_AluFlags_InLow;

   modport master (
      output CC_ALUARB_Req_In, CC_ALUARB_Sel0_In, CC_ALUARB_Sel1_In,
             CC_ALUARB_A0_In, CC_ALUARB_A1_In, CC_ALUARB_B0_In, CC_ALUARB_B1_In,
             CC_ALUARB_Rdy_In, CC_ALUARB_AluData_In, CC_ALUARB_AluFlags_InLow,
      input  CC_ALUARB_Gnt_Out, CC_ALUARB_Valid_Out, CC_ALUARB_Data_Out,
             CC_ALUARB_Flags_Out, CC_ALUARB_Drop_Out, CC_ALUARB_PSR_Out,
             CC_ALUARB_AluA_Out, CC_ALUARB_AluB_Out, CC_ALUARB_AluSel_Out
   );

   modport slave (
      input  CC_ALUARB_Req_In, CC_ALUARB_Sel0_In, CC_ALUARB_Sel1_In,
             CC_ALUARB_A0_In, CC_ALUARB_A1_In, CC_ALUARB_B0_In, CC_ALUARB_B1_In,
             CC_ALUARB_Rdy_In, CC_ALUARB_AluData_In, CC_ALUARB_AluFlags_InLow,
      output CC_ALUARB_Gnt_Out, CC_ALUARB_Valid_Out, CC_ALUARB_Data_Out,
             CC_ALUARB_Flags_Out, CC_ALUARB_Drop_Out, CC_ALUARB_PSR_Out,
             CC_ALUARB_AluA_Out, CC_ALUARB_AluB_Out, CC_ALUARB_AluSel_Out
   );

endinterface

// File: rtl/cc_alu_rr_arb2.sv
// Two-way round-robin pick. A lone request always wins; on a tie the
// requester that did not win last time is chosen.
module cc_alu_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   // Winner selection from the request pair and the last-winner pointer
   always_comb begin
      valid  = |req;
      winner = 1'b0;
      case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last;
         default: winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/cc_alu_arbiter.sv
// Round-robin arbiter sharing one CC_ALU between two requesters.
// Optional build macro CC_ALUARB_PSR_EN adds a sticky {N,Z,V,C} register
// updated only by the condition-code selections; without it PSR_Out is 0.
//
// state | meaning
// IDLE  | waiting for a request; grant pulse and operand latch happen here
// EXEC  | ALU driven from latched operands; result captured at the edge
// RESP  | Valid to owner until its Rdy or until MAX_HOLD cycles elapse
module cc_alu_arbiter #(
   parameter int DATAWIDTH_BUS           = 32,
   parameter int DATAWIDTH_ALU_SELECTION = 4,
   parameter int MAX_HOLD                = 15
) (
   input logic             CC_ALUARB_CLOCK_50,
   input logic             CC_ALUARB_RESET_InLow,
   cc_alu_arbiter_if.slave bus
);
   import cc_alu_pkg::*;

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam int BW    = DATAWIDTH_BUS;
   localparam int SW    = DATAWIDTH_ALU_SELECTION;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             owner_q, owner_d;
   logic [SW-1:0]    sel_q, sel_d;
   logic [BW-1:0]    a_q, a_d;
   logic [BW-1:0]    b_q, b_d;
   logic [BW-1:0]    data_q, data_d;
   logic [3:0]       flags_q, flags_d;
   logic             valid_q, valid_d;
   logic             drop_q, drop_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       gnt_c;
   logic             win;
   logic             win_vld;
`ifdef CC_ALUARB_PSR_EN
   logic [3:0]       psr_q, psr_d;
`endif

   cc_alu_rr_arb2 u_arb (
      .req    (bus.CC_ALUARB_Req_In),
      .last   (last_q),
      .winner (win),
      .valid  (win_vld)
   );

   // Next-state, operand latch, result capture and hold-timer logic
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      sel_d   = sel_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      flags_d = flags_q;
      valid_d = valid_q;
      drop_d  = 1'b0;
      cnt_d   = cnt_q;
      gnt_c   = 2'b00;
`ifdef CC_ALUARB_PSR_EN
      psr_d   = psr_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               owner_d    = win;
               gnt_c[win] = 1'b1;
               sel_d      = win ? bus.CC_ALUARB_Sel1_In : bus.CC_ALUARB_Sel0_In;
               a_d        = win ? bus.CC_ALUARB_A1_In   : bus.CC_ALUARB_A0_In;
               b_d        = win ? bus.CC_ALUARB_B1_In   : bus.CC_ALUARB_B0_In;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            data_d  = bus.CC_ALUARB_AluData_In;
            flags_d = ~bus.CC_ALUARB_AluFlags_InLow;
`ifdef CC_ALUARB_PSR_EN
            if (sel_q <= SW'(CC_SEL_MAX))
               psr_d = ~bus.CC_ALUARB_AluFlags_InLow;
`endif
            valid_d = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = RESP;
         end
         RESP: begin
            if (bus.CC_ALUARB_Rdy_In[owner_q]) begin
               valid_d = 1'b0;
               last_d  = owner_q;
               state_d = IDLE;
            end else if (cnt_q >= CNT_W'(MAX_HOLD)) begin
               drop_d  = 1'b1;
               valid_d = 1'b0;
               last_d  = owner_q;
               state_d = IDLE;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge CC_ALUARB_CLOCK_50 or negedge CC_ALUARB_RESET_InLow) begin
      if (!CC_ALUARB_RESET_InLow) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         sel_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         flags_q <= '0;
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef CC_ALUARB_PSR_EN
         psr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         sel_q   <= sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         flags_q <= flags_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
`ifdef CC_ALUARB_PSR_EN
         psr_q   <= psr_d;
`endif
      end
   end

   // Grant is decided in the IDLE cycle itself; reset masks it so every output reads 0
   assign bus.CC_ALUARB_Gnt_Out    = gnt_c & {2{CC_ALUARB_RESET_InLow}};
   assign bus.CC_ALUARB_Valid_Out  = {valid_q & owner_q, valid_q & ~owner_q};
   assign bus.CC_ALUARB_Data_Out   = data_q;
   assign bus.CC_ALUARB_Flags_Out  = flags_q;
   assign bus.CC_ALUARB_Drop_Out   = drop_q;
   assign bus.CC_ALUARB_AluA_Out   = a_q;
   assign bus.CC_ALUARB_AluB_Out   = b_q;
   assign bus.CC_ALUARB_AluSel_Out = sel_q;
`ifdef CC_ALUARB_PSR_EN
   assign bus.CC_ALUARB_PSR_Out    = psr_q;
`else
   assign bus.CC_ALUARB_PSR_Out    = 4'b0000;
`endif

endmodule

// File: tb/tb_cc_alu_arbiter.sv
// Directed bench for cc_alu_arbiter with a small behavioural CC_ALU.
module tb_cc_alu_arbiter;

   localparam int MAX_HOLD = 15;
`ifdef CC_ALUARB_PSR_EN
   localparam logic [3:0] PSR_EXP_NEG = 4'b1010;
`else
   localparam logic [3:0] PSR_EXP_NEG = 4'b0000;
`endif

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   cc_alu_arbiter_if #(.DATAWIDTH_BUS(32), .DATAWIDTH_ALU_SELECTION(4)) bus ();

   cc_alu_arbiter #(
      .DATAWIDTH_BUS(32), .DATAWIDTH_ALU_SELECTION(4), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .CC_ALUARB_CLOCK_50    (clk),
      .CC_ALUARB_RESET_InLow (rst_n),
      .bus                   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Behavioural ALU: result plus active-low {N,Z,V,C}
   logic [32:0] alu_sum;
   logic [31:0] alu_res;
   logic        alu_v, alu_c;
   always_comb begin
      alu_sum = {1'b0, bus.CC_ALUARB_AluA_Out} + {1'b0, bus.CC_ALUARB_AluB_Out};
      alu_res = alu_sum[31:0];
      alu_v   = 1'b0;
      alu_c   = 1'b0;
      case (bus.CC_ALUARB_AluSel_Out)
         4'd0: alu_res = bus.CC_ALUARB_AluA_Out & bus.CC_ALUARB_AluB_Out;
         4'd1: alu_res = bus.CC_ALUARB_AluA_Out | bus.CC_ALUARB_AluB_Out;
         4'd2: alu_res = ~(bus.CC_ALUARB_AluA_Out | bus.CC_ALUARB_AluB_Out);
         default: begin
            alu_res = alu_sum[31:0];
            alu_c   = alu_sum[32];
            alu_v   = (bus.CC_ALUARB_AluA_Out[31] == bus.CC_ALUARB_AluB_Out[31]) &&
                      (alu_sum[31] != bus.CC_ALUARB_AluA_Out[31]);
         end
      endcase
      bus.CC_ALUARB_AluData_In     = alu_res;
      bus.CC_ALUARB_AluFlags_InLow = ~{alu_res[31], (alu_res == 32'd0), alu_v, alu_c};
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.CC_ALUARB_Req_In = 2'b00;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // One transaction with immediate ready; returns what was observed (no checking here)
   task automatic run_txn(input logic who, input logic [3:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [1:0] g, output logic [1:0] v,
                          output logic [31:0] d, output logic [3:0] f,
                          output logic [3:0] p);
      if (who) begin
         bus.CC_ALUARB_Sel1_In = sel; bus.CC_ALUARB_A1_In = a; bus.CC_ALUARB_B1_In = b;
         bus.CC_ALUARB_Req_In  = 2'b10;
      end else begin
         bus.CC_ALUARB_Sel0_In = sel; bus.CC_ALUARB_A0_In = a; bus.CC_ALUARB_B0_In = b;
         bus.CC_ALUARB_Req_In  = 2'b01;
      end
      bus.CC_ALUARB_Rdy_In = 2'b11;
      @(negedge clk) g = bus.CC_ALUARB_Gnt_Out;
      @(posedge clk) #2 bus.CC_ALUARB_Req_In = 2'b00;
      @(posedge clk) #2;
      @(negedge clk);
      v = bus.CC_ALUARB_Valid_Out; d = bus.CC_ALUARB_Data_Out;
      f = bus.CC_ALUARB_Flags_Out; p = bus.CC_ALUARB_PSR_Out;
      @(posedge clk) #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.CC_ALUARB_Req_In = 2'b11;
      bus.CC_ALUARB_Rdy_In = 2'b00;
      bus.CC_ALUARB_Sel0_In = '0; bus.CC_ALUARB_Sel1_In = '0;
      bus.CC_ALUARB_A0_In = '0; bus.CC_ALUARB_A1_In = '0;
      bus.CC_ALUARB_B0_In = '0; bus.CC_ALUARB_B1_In = '0;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Gnt_Out !== 2'b00) begin errors++;
         $display("FAIL reset_gnt: got %b expected 00", bus.CC_ALUARB_Gnt_Out); end
      checks++; if (bus.CC_ALUARB_Valid_Out !== 2'b00) begin errors++;
         $display("FAIL reset_valid: got %b expected 00", bus.CC_ALUARB_Valid_Out); end
      checks++; if ({bus.CC_ALUARB_Data_Out, bus.CC_ALUARB_Flags_Out, bus.CC_ALUARB_PSR_Out,
                     bus.CC_ALUARB_Drop_Out} !== 41'd0) begin errors++;
         $display("FAIL reset_data_flags: got data %h flags %b psr %b drop %b expected all 0",
                  bus.CC_ALUARB_Data_Out, bus.CC_ALUARB_Flags_Out, bus.CC_ALUARB_PSR_Out,
                  bus.CC_ALUARB_Drop_Out); end
      checks++; if ({bus.CC_ALUARB_AluA_Out, bus.CC_ALUARB_AluB_Out, bus.CC_ALUARB_AluSel_Out} !== 68'd0)
         begin errors++;
         $display("FAIL reset_alu_ops: got a %h b %h sel %h expected 0",
                  bus.CC_ALUARB_AluA_Out, bus.CC_ALUARB_AluB_Out, bus.CC_ALUARB_AluSel_Out); end
      bus.CC_ALUARB_Req_In = 2'b00;
      @(posedge clk) #2 rst_n = 1'b1;
   endtask

   task automatic test_single_add();
      bus.CC_ALUARB_A0_In = 32'd5; bus.CC_ALUARB_B0_In = 32'd7; bus.CC_ALUARB_Sel0_In = 4'd8;
      bus.CC_ALUARB_Req_In = 2'b01; bus.CC_ALUARB_Rdy_In = 2'b11;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Gnt_Out !== 2'b01) begin errors++;
         $display("FAIL single_gnt_n: got %b expected 01", bus.CC_ALUARB_Gnt_Out); end
      @(posedge clk) #2 bus.CC_ALUARB_Req_In = 2'b00;
      @(negedge clk);
      checks++; if ({bus.CC_ALUARB_Gnt_Out, bus.CC_ALUARB_Valid_Out} !== 4'b0000) begin errors++;
         $display("FAIL single_exec_gv: got gnt %b valid %b expected 00 00",
                  bus.CC_ALUARB_Gnt_Out, bus.CC_ALUARB_Valid_Out); end
      checks++; if ({bus.CC_ALUARB_AluA_Out, bus.CC_ALUARB_AluB_Out, bus.CC_ALUARB_AluSel_Out}
                    !== {32'd5, 32'd7, 4'd8}) begin errors++;
         $display("FAIL single_alu_ops: got a %h b %h sel %h expected 5 7 8",
                  bus.CC_ALUARB_AluA_Out, bus.CC_ALUARB_AluB_Out, bus.CC_ALUARB_AluSel_Out); end
      @(posedge clk) #2;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Valid_Out !== 2'b01) begin errors++;
         $display("FAIL single_valid_n2: got %b expected 01", bus.CC_ALUARB_Valid_Out); end
      checks++; if (bus.CC_ALUARB_Data_Out !== 32'd12) begin errors++;
         $display("FAIL single_data: got %h expected 0000000c", bus.CC_ALUARB_Data_Out); end
      checks++; if (bus.CC_ALUARB_Flags_Out !== 4'b0000) begin errors++;
         $display("FAIL single_flags: got %b expected 0000", bus.CC_ALUARB_Flags_Out); end
      @(posedge clk) #2;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Valid_Out !== 2'b00) begin errors++;
         $display("FAIL single_valid_clear: got %b expected 00", bus.CC_ALUARB_Valid_Out); end
      @(posedge clk) #2;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      logic [31:0] exp_d;
      apply_reset();
      bus.CC_ALUARB_A0_In = 32'd1;  bus.CC_ALUARB_B0_In = 32'd2;  bus.CC_ALUARB_Sel0_In = 4'd8;
      bus.CC_ALUARB_A1_In = 32'd10; bus.CC_ALUARB_B1_In = 32'd20; bus.CC_ALUARB_Sel1_In = 4'd8;
      bus.CC_ALUARB_Rdy_In = 2'b11;
      bus.CC_ALUARB_Req_In = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_d = (k % 2 == 0) ? 32'd3 : 32'd30;
         @(negedge clk);
         checks++; if (bus.CC_ALUARB_Gnt_Out !== exp_g) begin errors++;
            $display("FAIL rr_gnt[%0d]: got %b expected %b", k, bus.CC_ALUARB_Gnt_Out, exp_g); end
         @(posedge clk) #2;
         @(posedge clk) #2;
         @(negedge clk);
         checks++; if (bus.CC_ALUARB_Valid_Out !== exp_g || bus.CC_ALUARB_Data_Out !== exp_d)
            begin errors++;
            $display("FAIL rr_resp[%0d]: got valid %b data %h expected %b %h",
                     k, bus.CC_ALUARB_Valid_Out, bus.CC_ALUARB_Data_Out, exp_g, exp_d); end
         @(posedge clk) #2;
      end
      bus.CC_ALUARB_Req_In = 2'b00;
   endtask

   task automatic test_addcc_flags();
      logic [1:0] g, v;
      logic [31:0] d;
      logic [3:0] f, p;
      run_txn(1'b1, 4'd3, 32'h7FFF_FFFF, 32'd1, g, v, d, f, p);
      checks++; if (g !== 2'b10 || v !== 2'b10) begin errors++;
         $display("FAIL addcc_neg_hs: got gnt %b valid %b expected 10 10", g, v); end
      checks++; if (d !== 32'h8000_0000 || f !== 4'b1010) begin errors++;
         $display("FAIL addcc_neg_result: got %h flags %b expected 80000000 1010", d, f); end
      checks++; if (p !== PSR_EXP_NEG) begin errors++;
         $display("FAIL addcc_neg_psr: got %b expected %b", p, PSR_EXP_NEG); end
      run_txn(1'b1, 4'd8, 32'd1, 32'd1, g, v, d, f, p);
      checks++; if (d !== 32'd2 || f !== 4'b0000) begin errors++;
         $display("FAIL add_after_cc: got %h flags %b expected 00000002 0000", d, f); end
      checks++; if (p !== PSR_EXP_NEG) begin errors++;
         $display("FAIL add_psr_hold: got %b expected %b", p, PSR_EXP_NEG); end
      run_txn(1'b0, 4'd3, 32'hFFFF_FFFF, 32'd1, g, v, d, f, p);
      checks++; if (g !== 2'b01 || v !== 2'b01) begin errors++;
         $display("FAIL addcc_zero_hs: got gnt %b valid %b expected 01 01", g, v); end
      checks++; if (d !== 32'd0 || f !== 4'b0101) begin errors++;
         $display("FAIL addcc_zero_result: got %h flags %b expected 00000000 0101", d, f); end
   endtask

   task automatic test_timeout();
      int vcount;
      bit ended;
      vcount = 0;
      ended  = 1'b0;
      bus.CC_ALUARB_A0_In = 32'd4; bus.CC_ALUARB_B0_In = 32'd4; bus.CC_ALUARB_Sel0_In = 4'd8;
      bus.CC_ALUARB_A1_In = 32'd6; bus.CC_ALUARB_B1_In = 32'd9; bus.CC_ALUARB_Sel1_In = 4'd8;
      bus.CC_ALUARB_Req_In = 2'b01; bus.CC_ALUARB_Rdy_In = 2'b00;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Gnt_Out !== 2'b01) begin errors++;
         $display("FAIL timeout_gnt0: got %b expected 01", bus.CC_ALUARB_Gnt_Out); end
      // R1 waits; its ready is high but must not release R0's response
      @(posedge clk) #2 begin bus.CC_ALUARB_Req_In = 2'b10; bus.CC_ALUARB_Rdy_In = 2'b10; end
      @(negedge clk);
      for (int i = 0; i < MAX_HOLD + 5; i++) begin
         @(negedge clk);
         if (bus.CC_ALUARB_Valid_Out == 2'b01) vcount++;
         else begin ended = 1'b1; break; end
      end
      checks++; if (!ended || vcount != MAX_HOLD) begin errors++;
         $display("FAIL timeout_hold_cycles: got %0d (ended %0d) expected %0d", vcount, ended, MAX_HOLD); end
      checks++; if (bus.CC_ALUARB_Drop_Out !== 1'b1 || bus.CC_ALUARB_Valid_Out !== 2'b00) begin errors++;
         $display("FAIL timeout_drop: got drop %b valid %b expected 1 00",
                  bus.CC_ALUARB_Drop_Out, bus.CC_ALUARB_Valid_Out); end
      checks++; if (bus.CC_ALUARB_Gnt_Out !== 2'b10) begin errors++;
         $display("FAIL timeout_next_gnt: got %b expected 10", bus.CC_ALUARB_Gnt_Out); end
      @(posedge clk) #2 bus.CC_ALUARB_Req_In = 2'b00;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Drop_Out !== 1'b0) begin errors++;
         $display("FAIL timeout_drop_pulse: got %b expected 0", bus.CC_ALUARB_Drop_Out); end
      @(posedge clk) #2;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Valid_Out !== 2'b10 || bus.CC_ALUARB_Data_Out !== 32'd15) begin errors++;
         $display("FAIL timeout_r1_resp: got valid %b data %h expected 10 0000000f",
                  bus.CC_ALUARB_Valid_Out, bus.CC_ALUARB_Data_Out); end
      @(posedge clk) #2;
   endtask

   task automatic test_reset_in_resp();
      bus.CC_ALUARB_A1_In = 32'h7FFF_FFFF; bus.CC_ALUARB_B1_In = 32'd1; bus.CC_ALUARB_Sel1_In = 4'd3;
      bus.CC_ALUARB_Req_In = 2'b10; bus.CC_ALUARB_Rdy_In = 2'b00;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Gnt_Out !== 2'b10) begin errors++;
         $display("FAIL rst_resp_gnt: got %b expected 10", bus.CC_ALUARB_Gnt_Out); end
      @(posedge clk) #2 bus.CC_ALUARB_Req_In = 2'b11;
      @(posedge clk) #2;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Valid_Out !== 2'b10 || bus.CC_ALUARB_Flags_Out !== 4'b1010) begin errors++;
         $display("FAIL rst_resp_pre: got valid %b flags %b expected 10 1010",
                  bus.CC_ALUARB_Valid_Out, bus.CC_ALUARB_Flags_Out); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if ({bus.CC_ALUARB_Valid_Out, bus.CC_ALUARB_Gnt_Out, bus.CC_ALUARB_Flags_Out,
                     bus.CC_ALUARB_PSR_Out} !== 12'd0 || bus.CC_ALUARB_Data_Out !== 32'd0) begin errors++;
         $display("FAIL rst_resp_async: got valid %b gnt %b data %h flags %b psr %b expected all 0",
                  bus.CC_ALUARB_Valid_Out, bus.CC_ALUARB_Gnt_Out, bus.CC_ALUARB_Data_Out,
                  bus.CC_ALUARB_Flags_Out, bus.CC_ALUARB_PSR_Out); end
      @(posedge clk) #2 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.CC_ALUARB_Gnt_Out !== 2'b01) begin errors++;
         $display("FAIL rst_resp_idle_r0: got %b expected 01", bus.CC_ALUARB_Gnt_Out); end
      @(posedge clk) #2 begin bus.CC_ALUARB_Req_In = 2'b00; bus.CC_ALUARB_Rdy_In = 2'b11; end
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_addcc_flags();
      test_timeout();
      test_reset_in_resp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
